// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph table, bus bundle and
// monitor FSM encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba glyphs, index = hex value
    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLING,
        ST_HELD
    } state_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } bus_t;

endpackage

// File: rtl/seg7_decode.sv
// Seven-segment glyph to hex nibble decoder; unknown patterns
// (blank included) flag err and return nibble 0.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       err
);

    always_comb begin
        nibble = '0;
        err    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPHS[i]) begin
                nibble = 4'(i);
                err    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg4x7_monitor.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment bus:
// debounces each digit dwell and republishes whole frames.
module seg4x7_monitor
    import seg7_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    input  logic        dp,
    output logic [15:0] data,
    output logic [3:0]  dp_mask,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    output logic        stale
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    bus_t          bus_q;
    bus_t          bus_prev;
    state_t        state;
    logic [CW-1:0] stable_cnt;
    logic [CW-1:0] next_cnt;
    logic [TW-1:0] idle_cnt;
    logic [15:0]   stg_data;
    logic [3:0]    stg_dp;
    logic [3:0]    stg_err;
    logic [3:0]    seen;
    logic [3:0]    seen_eff;
    logic [3:0]    dig;
    logic          pending;
    logic          legal;
    logic          changed;
    logic          capture;
    logic [3:0]    dec_nib;
    logic          dec_err;

    seg7_decode u_dec (
        .seg    (bus_q.seg),
        .nibble (dec_nib),
        .err    (dec_err)
    );

    always_comb begin
        dig      = ~bus_q.an;
        legal    = ($countones(dig) == 1);
        changed  = (bus_q != bus_prev);
        next_cnt = (state == ST_IDLE || changed)
                 ? CW'(1) : stable_cnt + 1'b1;
        capture  = legal
                 && (state != ST_HELD || changed)
                 && (next_cnt >= CW'(SETTLE));
        // seen is cleared on the completion edge, even if a capture lands there too
        seen_eff = pending ? 4'h0 : seen;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_q      <= '0;
            bus_prev   <= '0;
            state      <= ST_IDLE;
            stable_cnt <= '0;
        end else begin
            bus_q.an   <= an;
            bus_q.seg  <= seg;
            bus_q.dp   <= dp;
            bus_prev   <= bus_q;
            if (!legal) begin
                state      <= ST_IDLE;
                stable_cnt <= '0;
            end else if (capture) begin
                state      <= ST_HELD;
                stable_cnt <= next_cnt;
            end else if (state != ST_HELD || changed) begin
                state      <= ST_SETTLING;
                stable_cnt <= next_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_data <= '0;
            stg_dp   <= '0;
            stg_err  <= '0;
            seen     <= '0;
            pending  <= 1'b0;
        end else begin
            if (capture) begin
                for (int i = 0; i < 4; i++) begin
                    if (dig[i]) begin
                        stg_data[4*i +: 4] <= dec_nib;
                        stg_dp[i]          <= ~bus_q.dp;
                        stg_err[i]         <= dec_err;
                    end
                end
            end
            seen    <= capture ? (seen_eff | dig) : seen_eff;
            pending <= capture && ((seen_eff | dig) == 4'hF);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data        <= '0;
            dp_mask     <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            frame_valid <= pending;
            if (pending) begin
                data      <= stg_data;
                dp_mask   <= stg_dp;
                digit_err <= stg_err;
            end
            if (capture)
                idle_cnt <= '0;
            else if (idle_cnt != TW'(TIMEOUT))
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign stale = (idle_cnt == TW'(TIMEOUT));

endmodule

// File: tb/tb_seg4x7_monitor.sv
// Directed bench for seg4x7_monitor: frame table plus glitch,
// illegal-anode, stale and async-reset sequences.
module tb_seg4x7_monitor;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic        dp = 1'b1;
    logic [15:0] data;
    logic [3:0]  dp_mask;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        stale;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int base;

    typedef struct packed {
        logic [3:0][6:0] glyph;
        logic [3:0]      dp_on;
        logic [15:0]     exp_data;
        logic [3:0]      exp_dp;
        logic [3:0]      exp_err;
    } vec_t;

    vec_t vecs [4];

    seg4x7_monitor #(.SETTLE(4), .TIMEOUT(50)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg         (seg),
        .an          (an),
        .dp          (dp),
        .data        (data),
        .dp_mask     (dp_mask),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (frame_valid) fv_cnt++;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Drive bus at current negedge, hold for n cycles
    task automatic show(input logic [3:0] a, input logic [6:0] s,
                        input logic d, input int n);
        an  = a;
        seg = s;
        dp  = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic digit(input int i, input logic [6:0] s,
                         input logic lit, input int n);
        logic [3:0] one;
        one = 4'b0001 << i;
        show(~one, s, ~lit, n);
    endtask

    task automatic scan(input logic [3:0][6:0] g, input logic [3:0] d);
        for (int i = 3; i >= 0; i--) digit(i, g[i], d[i], 8);
        show(4'hF, 7'h7F, 1'b1, 4);
    endtask

    initial begin
        vecs[0] = '{glyph: {7'h79, 7'h24, 7'h30, 7'h19}, dp_on: 4'b0010,
                    exp_data: 16'h1234, exp_dp: 4'b0010, exp_err: 4'b0000};
        vecs[1] = '{glyph: {7'h40, 7'h7F, 7'h40, 7'h40}, dp_on: 4'b0000,
                    exp_data: 16'h0000, exp_dp: 4'b0000, exp_err: 4'b0100};
        vecs[2] = '{glyph: {7'h08, 7'h03, 7'h46, 7'h21}, dp_on: 4'b1001,
                    exp_data: 16'hABCD, exp_dp: 4'b1001, exp_err: 4'b0000};
        vecs[3] = '{glyph: {7'h0E, 7'h06, 7'h01, 7'h02}, dp_on: 4'b1111,
                    exp_data: 16'hFE06, exp_dp: 4'b1111, exp_err: 4'b0010};

        repeat (3) @(negedge clk);
        chk("rst_data", data, 16'h0);
        chk("rst_dp", {12'h0, dp_mask}, 16'h0);
        chk("rst_err", {12'h0, digit_err}, 16'h0);
        chk("rst_fv_stale", {14'h0, frame_valid, stale}, 16'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[k]) begin
            base = fv_cnt;
            scan(vecs[k].glyph, vecs[k].dp_on);
            chk($sformatf("v%0d_fv", k), 16'(fv_cnt - base), 16'd1);
            chk($sformatf("v%0d_data", k), data, vecs[k].exp_data);
            chk($sformatf("v%0d_dp", k), {12'h0, dp_mask},
                {12'h0, vecs[k].exp_dp});
            chk($sformatf("v%0d_err", k), {12'h0, digit_err},
                {12'h0, vecs[k].exp_err});
        end

        // glitch: digit 0 present only 3 cycles
        base = fv_cnt;
        digit(3, 7'h79, 1'b0, 8);
        digit(2, 7'h24, 1'b0, 8);
        digit(1, 7'h30, 1'b0, 8);
        digit(0, 7'h19, 1'b0, 3);
        show(4'hF, 7'h7F, 1'b1, 10);
        chk("glitch_nofv", 16'(fv_cnt - base), 16'd0);
        digit(0, 7'h40, 1'b0, 8);
        show(4'hF, 7'h7F, 1'b1, 4);
        chk("glitch_fv", 16'(fv_cnt - base), 16'd1);
        chk("glitch_data", data, 16'h1230);

        // two anodes low mid-scan
        base = fv_cnt;
        digit(3, 7'h46, 1'b0, 8);
        digit(2, 7'h21, 1'b0, 8);
        show(4'b0011, 7'h40, 1'b0, 20);
        chk("multi_nofv", 16'(fv_cnt - base), 16'd0);
        digit(1, 7'h08, 1'b0, 8);
        digit(0, 7'h03, 1'b0, 8);
        show(4'hF, 7'h7F, 1'b1, 4);
        chk("multi_fv", 16'(fv_cnt - base), 16'd1);
        chk("multi_data", data, 16'hCDAB);

        // stale: k = cycles since digit 3 capture
        base = fv_cnt;
        digit(3, 7'h12, 1'b0, 5);
        chk("stale_k0", {15'h0, stale}, 16'h0);
        show(4'hF, 7'h7F, 1'b1, 49);
        chk("stale_k49", {15'h0, stale}, 16'h0);
        show(4'hF, 7'h7F, 1'b1, 1);
        chk("stale_k50", {15'h0, stale}, 16'h1);
        show(4'hF, 7'h7F, 1'b1, 10);
        chk("stale_k60", {15'h0, stale}, 16'h1);
        digit(2, 7'h02, 1'b0, 4);
        chk("stale_k64", {15'h0, stale}, 16'h1);
        digit(2, 7'h02, 1'b0, 1);
        chk("stale_k65", {15'h0, stale}, 16'h0);
        digit(2, 7'h02, 1'b0, 3);
        digit(1, 7'h78, 1'b0, 8);
        digit(0, 7'h00, 1'b0, 8);
        show(4'hF, 7'h7F, 1'b1, 4);
        chk("stale_fv", 16'(fv_cnt - base), 16'd1);
        chk("stale_data", data, 16'h5678);

        // async reset with a partial frame staged
        digit(3, 7'h79, 1'b0, 8);
        digit(2, 7'h24, 1'b1, 8);
        digit(1, 7'h30, 1'b0, 8);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_data", data, 16'h0);
        repeat (3) @(negedge clk);
        chk("arst_hold", {8'h0, dp_mask, digit_err}, 16'h0);
        reset_n = 1'b1;
        show(4'hF, 7'h7F, 1'b1, 3);
        chk("arst_after", data, 16'h0);
        base = fv_cnt;
        scan(vecs[2].glyph, 4'b0000);
        chk("arst_fv", 16'(fv_cnt - base), 16'd1);
        chk("arst_frame", data, 16'hABCD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg4x7_monitor.md
Name: seg4x7_monitor

Overview:
- Receive-side decoder for the multiplexed 4-digit seven-segment bus that the display controller drives (seg, an, dp).
- Watches the time-multiplexed bus, filters anode/segment transitions, and decodes each digit's pattern back to a hex nibble.
- Publishes complete 4-digit frames as data[15:0] plus the decimal-point mask, recovering the value shown to the user.
- Used as an on-chip self-check of the stopwatch display path and as a bench monitor; no effect on the display itself.

Parameters:
- SETTLE, 4, consecutive clk cycles {an, seg, dp} must be unchanged before a digit is captured (min 1).
- TIMEOUT, 1000000, clk cycles without any capture before stale is asserted.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- seg  input  7  segment lines, active-low, seg[0]=a … seg[6]=g.
- an  input  4  anode enables, active-low, an[i] selects digit i (digit 3 = leftmost = data[15:12]).
- dp  input  1  decimal point, active-low.
- data  output  16  last complete frame, digit i in data[4i+3:4i].
- dp_mask  output  4  last complete frame; bit i=1 when digit i's dp was lit.
- digit_err  output  4  last complete frame; bit i=1 when digit i's pattern was not a legal hex glyph.
- frame_valid  output  1  one-cycle pulse when data/dp_mask/digit_err update.
- stale  output  1  level; no capture for TIMEOUT cycles.

Behaviour:
- Input handling: inputs are registered once (bus_q = {an, seg, dp}). All logic operates on bus_q; decoder latency is measured from bus_q.
- Reset: all outputs 0, seen mask 0, staging regs 0, FSM in IDLE, counters 0.
- Legal an: exactly one bit low. Any other value (0xF, multiple low) is "no digit".
- FSM:
  - IDLE: bus_q not legal. Go to SETTLING when bus_q becomes legal; stable_cnt=1.
  - SETTLING: bus_q unchanged increments stable_cnt. When stable_cnt reaches SETTLE, capture on that edge and go to HELD. Any change in bus_q goes to SETTLING (if the new value is legal, stable_cnt=1) or to IDLE.
  - HELD: no further capture while bus_q is unchanged, so there is exactly one capture per dwell. A change to a legal value goes to SETTLING; a change to an illegal value goes to IDLE.
- Capture of digit i:
  - Staging nibble[i] = decode(seg); staging dp[i] = ~dp; staging err[i] = pattern illegal (nibble forced 0).
  - seen[i] is set.
  - A repeat capture of a digit before the frame completes overwrites that digit's staging value.
- Decode table (gfedcba, active-low), 0–F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex). Every other pattern, including blank 7F, is illegal.
- Frame completion: on the cycle after the capture that makes seen == 4'hF:
  - data, dp_mask and digit_err load from staging.
  - frame_valid pulses high for 1 cycle.
  - seen clears.
  - Outputs hold between frames.
- Latency: SETTLE = S gives a capture edge S cycles after bus_q first shows the digit; frame_valid follows 1 cycle after the completing capture.
- Stale:
  - idle_cnt clears on every capture and otherwise saturates at TIMEOUT.
  - stale = (idle_cnt == TIMEOUT).
  - stale deasserts the cycle after the next capture.
  - stale never clears seen or the outputs.
- Reset mid-operation: asynchronous return to the reset state; any partial frame is discarded.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry glyph constants (shared with the display encoder);
  - the FSM state encoding IDLE/SETTLING/HELD;
  - the constant SEG_BLANK = 7'h7F.
- One natural sub-module, seg7_decode: combinational seg[6:0] → {err, nibble[3:0]} using the package table; instantiated once.

Test Plan:
- Scan digits 3..0 with glyphs 1,2,3,4 (79,24,30,19), dp lit on digit 1 only, dwell 8 cycles, SETTLE=4 -> one frame_valid pulse; data=16'h1234, dp_mask=4'b0010, digit_err=0.
- Digit 2 shows 7F, others show 0 (40) -> data=16'h0000, digit_err=4'b0100.
- Glitch: an held valid for 3 cycles then changed, SETTLE=4 -> no capture, seen unchanged, no frame_valid.
- Drive an=4'b0011 (two digits low) for 20 cycles mid-scan -> FSM stays IDLE, no capture. Resume a legal scan -> next frame completes normally.
- Capture digits 3,2,1, pulse reset_n low asynchronously, then scan A,b,C,d (08,03,46,21) -> only one frame_valid, data=16'hABCD. Outputs were 0 during and after reset until that frame.
- TIMEOUT=50, an=4'hF for 60 cycles -> stale=1 from cycle 50 after the last capture. One valid dwell -> stale=0 the cycle after its capture.
